// File: rtl/pattern_det_pkg.sv
// Shared defaults and the overlap-mode encoding for the serial pattern detector.
package pattern_det_pkg;

  localparam int         PAT_W_DEF   = 4;
  localparam logic [3:0] PAT_RST_DEF = 4'b1011;
  localparam int         CNT_W_DEF   = 8;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/moore_pattern_detector_sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, async active-low clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_pattern_detector_param.sv
// Moore serial pattern detector with run-time loadable pattern and saturating match count.
// Build macro PAT_MASK_EN adds a per-bit don't-care mask (pat_mask_in) loaded with the pattern.
module moore_pattern_detector_param
  import pattern_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef PAT_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  output logic             q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  mask_q, mask_d;
  logic [PAT_W-1:0]  shreg_q, shreg_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              q_q;
  logic [PAT_W-1:0]  shreg_nxt_s;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [PAT_W-1:0]  mask_load_s;
  logic              hit_s;
  ovl_mode_e         ovl_s;

`ifdef PAT_MASK_EN
  assign mask_load_s = pat_mask_in;
`else
  assign mask_load_s = {PAT_W{1'b1}};
`endif

  assign ovl_s = ovl_mode_e'(overlap);

  // A match is judged on the post-shift history so q rises one edge after the final bit.
  always_comb begin
    pattern_d   = pattern_q;
    mask_d      = mask_q;
    shreg_d     = shreg_q;
    fill_d      = fill_q;
    hit_s       = 1'b0;
    shreg_nxt_s = {shreg_q[PAT_W-2:0], in};
    fill_nxt_s  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    if (pat_load) begin
      pattern_d = pat_in;
      mask_d    = mask_load_s;
      shreg_d   = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hit_s = (fill_nxt_s == FILL_FULL) &&
              (((shreg_nxt_s ^ pattern_q) & mask_q) == '0);
      if (hit_s && (ovl_s == OVL_OFF)) begin
        shreg_d = '0;
        fill_d  = '0;
      end else begin
        shreg_d = shreg_nxt_s;
        fill_d  = fill_nxt_s;
      end
    end else begin
      shreg_d = shreg_q;
      fill_d  = fill_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= PAT_RST;
      mask_q    <= {PAT_W{1'b1}};
      shreg_q   <= '0;
      fill_q    <= '0;
      q_q       <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      shreg_q   <= shreg_d;
      fill_q    <= fill_d;
      q_q       <= hit_s;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (hit_s),
    .cnt_o  (match_cnt)
  );

  assign q = q_q;

endmodule
